// File: rtl/ram_access_scheduler_pkg.sv
// ram_access_scheduler_pkg
//   Shared definitions for the RAM access scheduler and its clear sequencer:
//   - state_t        : scheduler state (IDLE / CLEAR)
//   - calc_mem_size  : word-address width derived from the byte size and word
//                      width, shared with the RAM wrapper so both agree
package ram_access_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Byte-address bits minus the byte-in-word bits gives the word-address width.
  function automatic int calc_mem_size(input int size_bytes, input int width);
    return size_bytes - $clog2(width / 8);
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// ram_clear_sequencer
//   Sweeps every word address once, from 0 up to the last word, presenting a
//   latched clear value. The sweep starts on a start pulse in IDLE. Start
//   pulses during a sweep are ignored.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   i_start       : one-cycle pulse requesting a sweep
//   i_clear_data  : clear value, latched together with an accepted i_start
//   o_busy        : registered, high while the sweep is in progress
//   o_addr        : word address to write this cycle
//   o_data        : latched clear value
module ram_clear_sequencer
  import ram_access_scheduler_pkg::*;
#(
  parameter int MEM_SIZE  = 4,
  parameter int MEM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [MEM_WIDTH-1:0] i_clear_data,
  output logic                 o_busy,
  output logic [MEM_SIZE-1:0]  o_addr,
  output logic [MEM_WIDTH-1:0] o_data
);

  state_t                r_state;
  state_t                w_next_state;
  logic [MEM_SIZE-1:0]   r_count;
  logic [MEM_WIDTH-1:0]  r_clear_data;
  logic                  w_done;

  // The last word is being written this cycle.
  assign w_done = (r_count == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = CLEAR;
      CLEAR:   if (w_done)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The counter wraps naturally to 0 after the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_clear_data <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_count      <= '0;
      r_clear_data <= i_clear_data;
    end else if (r_state == CLEAR) begin
      r_count      <= r_count + 1'b1;
    end
  end

  assign o_busy = (r_state == CLEAR);
  assign o_addr = r_count;
  assign o_data = r_clear_data;

endmodule

// File: rtl/ram_access_scheduler.sv
// ram_access_scheduler
//   Front end for one simple dual-port RAM. The write port is shared between
//   pixel writes and a full-memory clear sweep; the sweep owns the port while
//   it runs. Reads are held off while a write to the same address is
//   presented, so a read never sees a same-cycle write. Read data is returned
//   one cycle after acceptance, with rdDataValid.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   clearStart, clearData      : clear request pulse and clear value
//   clearBusy                  : clear sweep in progress (registered)
//   wrValid/wrReady, wrAddr,
//   wrData, wrMask             : pixel-write request
//   rdValid/rdReady, rdAddr    : read request
//   rdDataValid, rdData        : read response
//   ramWrite*, ramRead*        : RAM port controls, ramReadData from RAM
module ram_access_scheduler
  import ram_access_scheduler_pkg::*;
#(
  parameter  int MEM_SIZE_BYTES     = 14,
  parameter  int MEM_WIDTH          = 16,
  parameter  int WRITE_STROBE_WIDTH = 4,
  localparam int MEM_SIZE           = calc_mem_size(MEM_SIZE_BYTES, MEM_WIDTH),
  localparam int WRITE_MASK_SIZE    = MEM_WIDTH / WRITE_STROBE_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clearStart,
  input  logic [MEM_WIDTH-1:0]       clearData,
  output logic                       clearBusy,
  input  logic                       wrValid,
  output logic                       wrReady,
  input  logic [MEM_SIZE-1:0]        wrAddr,
  input  logic [MEM_WIDTH-1:0]       wrData,
  input  logic [WRITE_MASK_SIZE-1:0] wrMask,
  input  logic                       rdValid,
  output logic                       rdReady,
  input  logic [MEM_SIZE-1:0]        rdAddr,
  output logic                       rdDataValid,
  output logic [MEM_WIDTH-1:0]       rdData,
  output logic                       ramWriteCs,
  output logic                       ramWrite,
  output logic [MEM_SIZE-1:0]        ramWriteAddr,
  output logic [MEM_WIDTH-1:0]       ramWriteData,
  output logic [WRITE_MASK_SIZE-1:0] ramWriteMask,
  output logic                       ramReadCs,
  output logic [MEM_SIZE-1:0]        ramReadAddr,
  input  logic [MEM_WIDTH-1:0]       ramReadData
);

  logic                 w_clear_busy;
  logic [MEM_SIZE-1:0]  w_clear_addr;
  logic [MEM_WIDTH-1:0] w_clear_data;
  logic                 w_collision;
  logic                 w_rd_accept;
  logic                 r_rd_vld_p1;

  ram_clear_sequencer #(
    .MEM_SIZE  (MEM_SIZE),
    .MEM_WIDTH (MEM_WIDTH)
  ) u_clear_seq (
    .clk          (clk),
    .reset        (reset),
    .i_start      (clearStart),
    .i_clear_data (clearData),
    .o_busy       (w_clear_busy),
    .o_addr       (w_clear_addr),
    .o_data       (w_clear_data)
  );

  // A write presented to the read address wins; the read waits until the
  // write is withdrawn.
  assign w_collision = wrValid && (wrAddr == rdAddr);
  assign wrReady     = !w_clear_busy;
  assign rdReady     = !w_clear_busy && !w_collision;
  assign w_rd_accept = rdValid && rdReady;

  // RAM controls are forced low while reset is held, even though the
  // requesters may still be driving.
  always_comb begin
    ramWriteCs   = 1'b0;
    ramWrite     = 1'b0;
    ramWriteAddr = '0;
    ramWriteData = '0;
    ramWriteMask = '0;
    ramReadCs    = 1'b0;
    ramReadAddr  = '0;
    if (!reset) begin
      if (w_clear_busy) begin
        ramWriteCs   = 1'b1;
        ramWrite     = 1'b1;
        ramWriteAddr = w_clear_addr;
        ramWriteData = w_clear_data;
        ramWriteMask = '1;
      end else if (wrValid) begin
        ramWriteCs   = 1'b1;
        ramWrite     = 1'b1;
        ramWriteAddr = wrAddr;
        ramWriteData = wrData;
        ramWriteMask = wrMask;
      end
      if (w_rd_accept) begin
        ramReadCs   = 1'b1;
        ramReadAddr = rdAddr;
      end
    end
  end

  // Read response stage: RAM has one cycle of read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd_accept;
    end
  end

  assign rdDataValid = r_rd_vld_p1;
  assign rdData      = ramReadData;
  assign clearBusy   = w_clear_busy;

endmodule

// File: tb/tb_ram_access_scheduler.sv
module tb_ram_access_scheduler;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clearStart;
  logic [DW-1:0] clearData;
  logic          clearBusy;
  logic          wrValid;
  logic          wrReady;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [MW-1:0] wrMask;
  logic          rdValid;
  logic          rdReady;
  logic [AW-1:0] rdAddr;
  logic          rdDataValid;
  logic [DW-1:0] rdData;
  logic          ramWriteCs;
  logic          ramWrite;
  logic [AW-1:0] ramWriteAddr;
  logic [DW-1:0] ramWriteData;
  logic [MW-1:0] ramWriteMask;
  logic          ramReadCs;
  logic [AW-1:0] ramReadAddr;
  logic [DW-1:0] ramReadData = '0;

  logic [DW-1:0] ram     [NW] = '{default: 16'h0000};
  logic [DW-1:0] exp_mem [NW] = '{default: 16'h0000};
  logic [DW-1:0] sb_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  ram_access_scheduler #(
    .MEM_SIZE_BYTES     (5),
    .MEM_WIDTH          (16),
    .WRITE_STROBE_WIDTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clearStart   (clearStart),
    .clearData    (clearData),
    .clearBusy    (clearBusy),
    .wrValid      (wrValid),
    .wrReady      (wrReady),
    .wrAddr       (wrAddr),
    .wrData       (wrData),
    .wrMask       (wrMask),
    .rdValid      (rdValid),
    .rdReady      (rdReady),
    .rdAddr       (rdAddr),
    .rdDataValid  (rdDataValid),
    .rdData       (rdData),
    .ramWriteCs   (ramWriteCs),
    .ramWrite     (ramWrite),
    .ramWriteAddr (ramWriteAddr),
    .ramWriteData (ramWriteData),
    .ramWriteMask (ramWriteMask),
    .ramReadCs    (ramReadCs),
    .ramReadAddr  (ramReadAddr),
    .ramReadData  (ramReadData)
  );

  // Behavioural simple dual-port RAM, 1-cycle read latency, nibble lanes.
  always @(posedge clk) begin
    if (ramWriteCs && ramWrite) begin
      for (int l = 0; l < MW; l++) begin
        if (ramWriteMask[l]) ram[ramWriteAddr][4*l +: 4] <= ramWriteData[4*l +: 4];
      end
    end
    if (ramReadCs) ramReadData <= ram[ramReadAddr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int l = 0; l < MW; l++) if (m[l]) r[4*l +: 4] = new_w[4*l +: 4];
    return r;
  endfunction

  // Scoreboard: every rdDataValid pops the oldest expected read.
  always @(negedge clk) begin
    if (rdDataValid) begin
      if (sb_q.size() == 0) chk("rd_unexpected", 32'(rdDataValid), 0);
      else                  chk("rd_data", 32'(rdData), 32'(sb_q.pop_front()));
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    wrValid = 1'b1; wrAddr = a; wrData = d; wrMask = m;
    #1;
    chk("wr_ready", 32'(wrReady), 1);
    chk("wr_cs", 32'(ramWriteCs), 1);
    chk("wr_addr", 32'(ramWriteAddr), 32'(a));
    exp_mem[a] = merge(exp_mem[a], d, m);
    cyc();
    wrValid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rdValid = 1'b1; rdAddr = a;
    #1;
    chk("rd_ready", 32'(rdReady), 1);
    chk("rd_cs", 32'(ramReadCs), 1);
    sb_q.push_back(exp_mem[a]);
    cyc();
    rdValid = 1'b0;
  endtask

  task automatic rd_all();
    for (int a = 0; a < NW; a++) rd(AW'(a));
    cyc();
  endtask

  task automatic clr(input logic [DW-1:0] d, input bit hold, input bit restart,
                     input bit rd_start, input int abort_at);
    clearStart = 1'b1; clearData = d;
    if (rd_start) begin rdValid = 1'b1; rdAddr = 4'd4; end
    #1;
    chk("clr_start_busy", 32'(clearBusy), 0);
    if (rd_start) begin
      chk("clr_start_rdready", 32'(rdReady), 1);
      sb_q.push_back(exp_mem[4]);
    end
    cyc();
    clearStart = 1'b0; clearData = 16'hDEAD; rdValid = 1'b0;
    if (hold) begin
      wrValid = 1'b1; wrAddr = 4'd9; wrData = 16'h9999; wrMask = 4'hF;
      rdValid = 1'b1; rdAddr = 4'd2;
    end
    for (int i = 0; i < NW; i++) begin
      #1;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(clearBusy), 0);
        chk("abort_rdvalid", 32'(rdDataValid), 0);
        chk("abort_wcs", 32'(ramWriteCs), 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("abort_after_busy", 32'(clearBusy), 0);
        chk("abort_after_wrready", 32'(wrReady), 1);
        return;
      end
      chk("clr_busy", 32'(clearBusy), 1);
      chk("clr_wrready", 32'(wrReady), 0);
      chk("clr_rdready", 32'(rdReady), 0);
      chk("clr_wcs", 32'(ramWriteCs), 1);
      chk("clr_waddr", 32'(ramWriteAddr), 32'(i));
      chk("clr_wdata", 32'(ramWriteData), 32'(d));
      chk("clr_wmask", 32'(ramWriteMask), 32'hF);
      chk("clr_rcs", 32'(ramReadCs), 0);
      exp_mem[i] = d;
      if (restart && i == 7) begin clearStart = 1'b1; clearData = 16'hBEEF; end
      if (i == 8) clearStart = 1'b0;
      if (i == NW - 1) begin wrValid = 1'b0; rdValid = 1'b0; end
      cyc();
    end
    #1;
    chk("clr_end_busy", 32'(clearBusy), 0);
    chk("clr_end_wrready", 32'(wrReady), 1);
    chk("clr_end_rdready", 32'(rdReady), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clearStart = 1'b0; clearData = '0;
    wrValid = 1'b1; wrAddr = 4'd7; wrData = 16'hFFFF; wrMask = 4'hF;
    rdValid = 1'b1; rdAddr = 4'd1;
    cyc();
    #1;
    chk("rst_busy", 32'(clearBusy), 0);
    chk("rst_rdvalid", 32'(rdDataValid), 0);
    chk("rst_wcs", 32'(ramWriteCs), 0);
    chk("rst_wr", 32'(ramWrite), 0);
    chk("rst_wdata", 32'(ramWriteData), 0);
    chk("rst_rcs", 32'(ramReadCs), 0);
    wrValid = 1'b0; rdValid = 1'b0;
    reset = 1'b0;
    cyc();

    // Full and partial-mask writes.
    wr(4'd3, 16'hABCD, 4'b1111);
    rd(4'd3);
    cyc();
    wr(4'd3, 16'h1234, 4'b0101);
    rd(4'd3);
    cyc();
    chk("mask_model", 32'(exp_mem[3]), 32'hA2C4);

    // Clear sweep with requesters held active throughout.
    clr(16'h00FF, 1'b1, 1'b0, 1'b0, NW);
    rd_all();

    // Restart pulse mid-sweep is ignored.
    clr(16'h0F0F, 1'b0, 1'b1, 1'b0, NW);
    rd_all();

    // Same-address collision: write wins, read waits.
    wrValid = 1'b1; wrAddr = 4'd5; wrData = 16'h5A5A; wrMask = 4'hF;
    rdValid = 1'b1; rdAddr = 4'd5;
    #1;
    chk("coll_rdready", 32'(rdReady), 0);
    chk("coll_rcs", 32'(ramReadCs), 0);
    chk("coll_wrready", 32'(wrReady), 1);
    chk("coll_wcs", 32'(ramWriteCs), 1);
    exp_mem[5] = 16'h5A5A;
    cyc();
    wrValid = 1'b0;
    #1;
    chk("coll_after_rdready", 32'(rdReady), 1);
    sb_q.push_back(exp_mem[5]);
    cyc();
    rdValid = 1'b0;
    cyc();

    // Different addresses in the same cycle: both go.
    wrValid = 1'b1; wrAddr = 4'd6; wrData = 16'h6666; wrMask = 4'hF;
    rdValid = 1'b1; rdAddr = 4'd5;
    #1;
    chk("dual_rdready", 32'(rdReady), 1);
    chk("dual_wcs", 32'(ramWriteCs), 1);
    chk("dual_raddr", 32'(ramReadAddr), 5);
    sb_q.push_back(exp_mem[5]);
    exp_mem[6] = 16'h6666;
    cyc();
    wrValid = 1'b0; rdValid = 1'b0;
    rd(4'd6);
    cyc();

    // Reset at sweep cycle 8, with a read accepted in the clearStart cycle.
    clr(16'h3C3C, 1'b0, 1'b0, 1'b1, 8);
    cyc();
    rd_all();

    cyc();
    chk("sb_left", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_access_scheduler.md
# ram_access_scheduler

Controller in front of a single simple dual-port RAM instance, e.g. a tile colour or depth buffer. It shares the RAM write port between a pixel-write requester and a built-in clear sequencer. The clear sequencer sweeps the whole memory with a clear value. The block also gates the read port so that reads never observe a write to the same address in the same cycle, and it returns read data with a valid flag.

## Interface
- MEM_SIZE_BYTES, 14, memory size as power-of-two bytes (must match the RAM)
- MEM_WIDTH, 16, word width in bits
- WRITE_STROBE_WIDTH, 4, bits per write-mask lane
- MEM_SIZE (derived), MEM_SIZE_BYTES - clog2(MEM_WIDTH/8), word address width
- WRITE_MASK_SIZE (derived), MEM_WIDTH / WRITE_STROBE_WIDTH
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- clearStart  in  1  one-cycle pulse requesting a full-memory clear
- clearData  in  MEM_WIDTH  clear value, sampled with clearStart
- clearBusy  out  1  clear sweep in progress
- wrValid / wrReady  in / out  1  pixel-write handshake
- wrAddr  in  MEM_SIZE  pixel-write word address
- wrData  in  MEM_WIDTH  pixel-write data
- wrMask  in  WRITE_MASK_SIZE  pixel-write lane mask
- rdValid / rdReady  in / out  1  read-request handshake
- rdAddr  in  MEM_SIZE  read word address
- rdDataValid  out  1  rdData is valid this cycle
- rdData  out  MEM_WIDTH  read data (pass-through of ramReadData)
- ramWriteCs, ramWrite  out  1  RAM write controls
- ramWriteAddr  out  MEM_SIZE  RAM write address
- ramWriteData  out  MEM_WIDTH  RAM write data
- ramWriteMask  out  WRITE_MASK_SIZE  RAM write mask
- ramReadCs  out  1  RAM read enable
- ramReadAddr  out  MEM_SIZE  RAM read address
- ramReadData  in  MEM_WIDTH  RAM read data, 1-cycle latency

## Operation
- FSM with two states, IDLE and CLEAR.
- IDLE:
  - wrReady = 1.
  - On wrValid, drive ramWriteCs = ramWrite = 1 with wrAddr, wrData and wrMask, combinationally in the same cycle.
- IDLE → CLEAR on clearStart:
  - Latch clearData.
  - Reset the sweep counter to 0.
  - A pixel write presented in the clearStart cycle is still accepted, because wrReady is still 1.
- CLEAR:
  - wrReady = 0 and rdReady = 0.
  - Each cycle write word = counter with mask all ones and the latched clear value, then counter += 1.
  - After address 2^MEM_SIZE-1 is written, go to IDLE; the counter wraps to 0.
- clearStart while in CLEAR is ignored; clearData is not re-latched.
- Read acceptance:
  - rdReady = (state == IDLE) && !(wrValid && wrAddr == rdAddr).
  - A same-address collision stalls the read for as long as the write is presented; the write always has priority.
  - An accepted read drives ramReadCs = 1 with ramReadAddr = rdAddr.
  - rdDataValid is a register set to the accepted-read flag.
- Reset values:
  - state = IDLE, counter = 0, clearBusy = 0, rdDataValid = 0.
  - All ram* outputs are 0 while reset is asserted.
  - Latched clear value = 0.
- Reset asserted mid-clear aborts the sweep immediately and leaves memory partially cleared. Software must reissue clearStart.

## Timing
- Pixel write: 0-cycle issue; the data is in RAM after the accepting edge.
- Read: accepted at edge N; rdDataValid = 1 and rdData valid in cycle N+1.
- Back-to-back reads sustain 1 read per cycle.
- clearStart at edge N:
  - clearBusy = 1 from cycle N+1.
  - Writes to addresses 0 … 2^MEM_SIZE-1 occur in cycles N+1 … N+2^MEM_SIZE.
  - clearBusy = 0 and wrReady = rdReady = 1 from cycle N+2^MEM_SIZE+1.
- clearBusy is a registered output equal to (state == CLEAR).
- A read accepted in the clearStart cycle completes normally in the following cycle.

## Structure
- Shared package contains:
  - the state typedef (IDLE, CLEAR);
  - a function deriving MEM_SIZE from MEM_SIZE_BYTES and MEM_WIDTH, reused by the RAM wrapper.
- One natural sub-module, ram_clear_sequencer:
  - contains the counter, the latched clear value and the done flag;
  - interface: start in, busy out, addr out, data out.
- Top level holds the write mux, the read-collision gating and the rdDataValid register.

## Test plan
Bench parameters: MEM_SIZE_BYTES=5, MEM_WIDTH=16, WRITE_STROBE_WIDTH=4, giving 16 words and a 4-lane mask; the bench uses a behavioural RAM model.
- Write addr 3, data 0xABCD, mask 4'b1111; next cycle read addr 3 → rdDataValid=1 one cycle later with rdData=0xABCD.
- Write addr 3, data 0x1234, mask 4'b0101 over 0xABCD → read returns 0xA2C4.
- clearStart with clearData=0x00FF:
  - clearBusy is high for exactly 16 cycles;
  - wrReady and rdReady are 0 throughout;
  - afterwards all 16 words read 0x00FF.
- wrValid addr 5 and rdValid addr 5 in the same cycle → rdReady=0, write completes; next cycle (write dropped) the read is accepted and returns the new data. Different addresses in the same cycle → both accepted.
- clearStart pulsed again at sweep cycle 7 → ignored; the sweep ends at cycle 16 with the original value.
- Assert reset at sweep cycle 8:
  - clearBusy = 0 and rdDataValid = 0 immediately;
  - words 0–7 hold the clear value and words 8–15 keep their old contents.
